nibble_mux: RTL and testbench



---
 rtl/nibble_mux.sv | 93 +++++++++
 tb/tb_nibble_mux.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_mux.sv
// Board-edge 2:1 nibble selector: synchronizes the switch bank and push-button,
// debounces the button into a stable select and registers the chosen nibble onto the LEDs.
module nibble_mux #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       pba,
  output logic [3:0] led
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [7:0]             sw_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] pba_sync_q;
  logic [7:0]             sw_s;
  logic                   pba_s;

  logic          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    led_q, led_d;

  // Per-stage flops keep the chain a plain shift register the tools recognise as a synchronizer.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sw_sync
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sw_sync_q[gi] <= '0;
        end else if (gi == 0) begin
          sw_sync_q[gi] <= sw;
        end else begin
          sw_sync_q[gi] <= sw_sync_q[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pba_sync_q <= '0;
    end else begin
      pba_sync_q <= {pba_sync_q[SYNC_STAGES-2:0], pba};
    end
  end

  assign sw_s  = sw_sync_q[SYNC_STAGES-1];
  assign pba_s = pba_sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      always_comb begin
        sel_d = pba_s;
        cnt_d = '0;
      end
    end else begin : g_debounce
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
      // Any sample that agrees with the current select restarts the count.
      always_comb begin
        sel_d = sel_q;
        cnt_d = cnt_q;
        if (pba_s == sel_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          sel_d = pba_s;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  endgenerate

  always_comb begin
    led_d = sel_q ? sw_s[7:4] : sw_s[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 1'b0;
      cnt_q <= '0;
      led_q <= '0;
    end else begin
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_nibble_mux.sv
// Self-checking bench for nibble_mux: directed board scenarios plus randomized
// switch/button traffic compared against an edge-history reference model.
module tb_nibble_mux;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw;
  logic       pba;
  logic [3:0] led;

  int checks   = 0;
  int failures = 0;

  nibble_mux #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .pba   (pba),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: inputs seen at every rising edge since reset are kept in full;
  // the select flips once the last D synchronized samples all disagree with it.
  logic [7:0] sw_in [$];
  bit         p_in  [$];
  bit         sel_m;
  logic [3:0] led_exp;

  function automatic logic [7:0] sws(int k);
    int i = k - S;
    return (i >= 0) ? sw_in[i] : 8'h00;
  endfunction

  function automatic bit pbs(int k);
    int i = k - S;
    return (i >= 0) ? p_in[i] : 1'b0;
  endfunction

  task automatic model_reset();
    sw_in.delete();
    p_in.delete();
    sel_m   = 1'b0;
    led_exp = 4'h0;
  endtask

  task automatic model_edge();
    int         k;
    logic [7:0] prev;
    bit         all_diff;
    k    = sw_in.size() + 1;
    prev = sws(k - 1);
    led_exp = sel_m ? prev[7:4] : prev[3:0];
    if (D == 0) begin
      sel_m = pbs(k - 1);
    end else begin
      all_diff = 1'b1;
      for (int j = 1; j <= D; j++) begin
        if (pbs(k - j) == sel_m) all_diff = 1'b0;
      end
      if (all_diff) sel_m = ~sel_m;
    end
    sw_in.push_back(sw);
    p_in.push_back(pba);
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s led=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge; inputs only ever change at the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    chk(tag, led, led_exp);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 chk("rst_async", led, 4'h0);
    model_reset();
    @(negedge clk);
    tick("rst_hold");
    tick("rst_hold");
    rst_n = 1'b1;
  endtask

  task automatic settle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  logic [7:0] pats [8] = '{8'h00, 8'hFF, 8'h0F, 8'hF0, 8'h5A, 8'hA5, 8'h81, 8'h7E};

  initial begin
    bit         pba_v;
    int         run;
    logic [7:0] p;

    // Power-on reset with everything high at the pins.
    rst_n = 1'b0;
    sw    = 8'hFF;
    pba   = 1'b1;
    model_reset();
    #1 chk("por", led, 4'h0);
    for (int i = 0; i < 3; i++) tick("por_hold");
    rst_n = 1'b1;
    tick("por_e1");
    tick("por_e2");
    for (int i = 3; i <= 12; i++) begin
      tick("por_run");
      chk("por_ff", led, 4'hF);
    end
    $display("reset: led=%h after release", led);

    // Channel 0 latency.
    pba = 1'b0;
    sw  = 8'h00;
    settle(10, "ch0_settle");
    sw = 8'hA5;
    tick("ch0_e1");
    tick("ch0_e2");
    chk("ch0_e2_old", led, 4'h0);
    tick("ch0_e3");
    chk("ch0_e3", led, 4'h5);
    $display("channel0: led=%h", led);

    // Channel 1 latency.
    pba = 1'b1;
    for (int i = 1; i <= 6; i++) tick("ch1_wait");
    chk("ch1_e6", led, 4'h5);
    tick("ch1_e7");
    chk("ch1_e7", led, 4'hA);
    $display("channel1: led=%h", led);

    // Bounce rejection.
    pba = 1'b0;
    sw  = 8'hC3;
    settle(10, "bnc_settle");
    chk("bnc_start", led, 4'h3);
    pba = 1'b1; tick("bnc"); tick("bnc");
    pba = 1'b0; tick("bnc");
    pba = 1'b1; tick("bnc"); tick("bnc");
    pba = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick("bnc");
      chk("bnc_hold", led, 4'h3);
    end
    $display("bounce: led=%h", led);

    // Sweep both channels over fixed patterns.
    for (int s = 0; s < 2; s++) begin
      pba = s[0];
      for (int i = 0; i < 8; i++) begin
        sw = pats[i];
        settle(10, "sweep_settle");
        p = pats[i];
        chk("sweep", led, s[0] ? p[7:4] : p[3:0]);
        $display("sweep: pba=%0d sw=%h led=%h", s, p, led);
      end
    end

    // Reset in the middle of a debounce.
    pba = 1'b0;
    sw  = 8'hA5;
    settle(10, "mid_settle");
    pba = 1'b1;
    settle(5, "mid_count");
    chk("mid_pre", led, 4'h5);
    do_reset();
    for (int i = 1; i <= 6; i++) tick("mid_wait");
    chk("mid_e6", led, 4'h5);
    tick("mid_e7");
    chk("mid_e7", led, 4'hA);
    $display("mid-debounce reset: led=%h", led);

    // Randomized traffic with varying button run lengths and occasional resets.
    run = 0;
    pba_v = 1'b0;
    for (int t = 0; t < 1500; t++) begin
      if (run == 0) begin
        pba_v = 1'($urandom_range(0, 1));
        run   = $urandom_range(1, 9);
      end
      run--;
      pba = pba_v;
      if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      tick("rand");
    end
    $display("random: done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
